// File: rtl/gf_inv_16_if.sv
// gf_inv_16_if: request/response bundle for the GF(2^16) inverter.
//   i_start  request, sampled only while the inverter is idle
//   i_x      operand {x1, x0}
//   o_o      result {hi, lo}, valid while o_done = 1, held afterwards
//   o_done   one-cycle completion pulse
//   o_busy   high while an inversion is in flight
//   o_zero   operand-was-zero flag (only with GF_INV16_ZERO_FLAG_EN)
// Modports: master = requester, slave = inverter.
interface gf_inv_16_if;
    logic        i_start;
    logic [15:0] i_x;
    logic [15:0] o_o;
    logic        o_done;
    logic        o_busy;
`ifdef GF_INV16_ZERO_FLAG_EN
    logic        o_zero;

    modport master (output i_start, i_x, input o_o, o_done, o_busy, o_zero);
    modport slave  (input i_start, i_x, output o_o, o_done, o_busy, o_zero);
`else
    modport master (output i_start, i_x, input o_o, o_done, o_busy);
    modport slave  (input i_start, i_x, output o_o, o_done, o_busy);
`endif
endinterface

// File: rtl/gf_inv_16.sv
// gf_inv_16: sequential multiplicative inverter for GF(2^16), tower form
// GF(2^8)[Y]/(Y^2 + Y + 0x20), GF(2^8) reduced by 0x11B.
//   x = x1*Y + x0,  N = x0*(x0^x1) ^ 0x20*x1^2,
//   x^-1 = (x1*N^-1)*Y + (x0^x1)*N^-1,  N^-1 = N^254.
// One combinational GF(256) multiplier is time-shared over 18 steps:
// 3 norm steps, 13 exponentiation steps, 2 output steps. Latency is a
// fixed 18 cycles after the accepting edge; throughput one result per 19.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (aborts any in-flight operation)
//   bus    gf_inv_16_if.slave (i_start, i_x, o_o, o_done, o_busy[, o_zero])
// Optional feature macro: GF_INV16_ZERO_FLAG_EN adds o_zero, registered at
// the accepting edge as (i_x == 0). Zero input always yields 0x0000.
module gf_inv_16 (
    input  logic        i_clk,
    input  logic        i_rst,
    gf_inv_16_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, NORM, EXP, OUT} state_t;

    state_t      state_q, state_d;
    logic [15:0] xr;
    logic [7:0]  acc, nb, m1;
    logic [3:0]  cnt;
    logic [15:0] o_q;
    logic        done_q;
    logic [7:0]  x0, x1, x01;
    logic [7:0]  mul_a, mul_b, prod;
    logic        last_step;

    assign x1  = xr[15:8];
    assign x0  = xr[7:0];
    assign x01 = x0 ^ x1;

    // Shift-and-add GF(256) product, reduced mod 0x11B in the same cycle.
    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Operand selection for the shared multiplier.
    always_comb begin
        mul_a = acc;
        mul_b = acc;
        case (state_q)
            NORM: begin
                case (cnt)
                    4'd0:    begin mul_a = x0;    mul_b = x01; end
                    4'd1:    begin mul_a = x1;    mul_b = x1;  end
                    default: begin mul_a = 8'h20; mul_b = acc; end
                endcase
            end
            // Chain N^2, N^3, N^6, ... N^127, N^254: even counts square,
            // odd counts multiply by N.
            EXP: begin
                mul_a = acc;
                mul_b = cnt[0] ? nb : acc;
            end
            OUT: begin
                mul_a = cnt[0] ? x01 : x1;
                mul_b = acc;
            end
            default: begin
                mul_a = acc;
                mul_b = acc;
            end
        endcase
    end

    assign prod = gf256_mul(mul_a, mul_b);

    always_comb begin
        last_step = 1'b0;
        case (state_q)
            NORM:    last_step = (cnt == 4'd2);
            EXP:     last_step = (cnt == 4'd12);
            OUT:     last_step = (cnt == 4'd1);
            default: last_step = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = NORM;
            NORM:    if (last_step)   state_d = EXP;
            EXP:     if (last_step)   state_d = OUT;
            OUT:     if (last_step)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            xr     <= 16'h0000;
            acc    <= 8'h00;
            nb     <= 8'h00;
            m1     <= 8'h00;
            cnt    <= 4'd0;
            o_q    <= 16'h0000;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        xr  <= bus.i_x;
                        cnt <= 4'd0;
                    end
                end
                NORM: begin
                    case (cnt)
                        4'd0:    m1  <= prod;
                        4'd1:    acc <= prod;
                        default: begin
                            nb  <= m1 ^ prod;
                            acc <= m1 ^ prod;
                        end
                    endcase
                end
                EXP: acc <= prod;
                OUT: begin
                    if (cnt == 4'd0) begin
                        o_q[15:8] <= prod;
                    end else begin
                        o_q[7:0] <= prod;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_q != IDLE) cnt <= last_step ? 4'd0 : cnt + 4'd1;
        end
    end

    assign bus.o_o    = o_q;
    assign bus.o_done = done_q;
    assign bus.o_busy = (state_q != IDLE);

`ifdef GF_INV16_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)                                  zero_q <= 1'b0;
        else if (state_q == IDLE && bus.i_start)    zero_q <= (bus.i_x == 16'h0000);
    end

    assign bus.o_zero = zero_q;
`endif

endmodule

// File: tb/tb_gf_inv_16.sv
// tb_gf_inv_16: self-checking bench for gf_inv_16. The reference inverse is
// x^(2^16 - 2) computed by square-and-multiply over a tower-field multiply
// model; results are also round-tripped through that multiply.
module tb_gf_inv_16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    gf_inv_16_if bus ();

    gf_inv_16 dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 0; aa = a; bb = b;
        while (bb != 0) begin
            if (bb[0]) p ^= aa;
            aa = (aa << 1) ^ ((aa & 8'h80) != 0 ? 8'h1B : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // (a1 Y + a0)(b1 Y + b0) with Y^2 = Y + 0x20
    function automatic logic [15:0] gf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] hh;
        logic [7:0] hi;
        logic [7:0] lo;
        hh = gf8_mul(a[15:8], b[15:8]);
        hi = hh ^ gf8_mul(a[15:8], b[7:0]) ^ gf8_mul(a[7:0], b[15:8]);
        lo = gf8_mul(a[7:0], b[7:0]) ^ gf8_mul(8'h20, hh);
        return {hi, lo};
    endfunction

    function automatic logic [15:0] ref_inv(input logic [15:0] x);
        logic [15:0] r;
        logic [15:0] b;
        int          e;
        r = 16'h0001; b = x; e = 65534;
        for (int i = 0; i < 16; i++) begin
            if (((e >> i) & 1) == 1) r = gf16_mul(r, b);
            b = gf16_mul(b, b);
        end
        return r;
    endfunction

    task automatic run_op(input logic [15:0] xv, output logic [15:0] r, output int lat,
                          output int bcnt, output logic done_after);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_x     = xv;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_x     = 16'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!bus.o_done && lat < 40) begin
            if (bus.o_busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = bus.o_o;
        @(negedge clk);
        done_after = bus.o_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_x = 16'h0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.o_o !== 16'h0000 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: o_o=%h done=%b busy=%b, want 0000/0/0", bus.o_o, bus.o_done, bus.o_busy);
        end
`ifdef GF_INV16_ZERO_FLAG_EN
        n_vec++;
        if (bus.o_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_zero: o_zero=%b want 0", bus.o_zero);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_known();
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        logic [15:0] r;
        int          lat, bcnt;
        logic        da;
        xs = '{16'h0001, 16'h0002, 16'h0100, 16'h0000};
        ys = '{16'h0001, 16'h008D, 16'h3A3A, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], r, lat, bcnt, da);
            n_vec++;
            if (r !== ys[i]) begin
                n_err++;
                $display("FAIL known x=%h: got %h want %h", xs[i], r, ys[i]);
            end
            n_vec++;
            if (lat !== 18 || bcnt !== 18 || da !== 1'b0) begin
                n_err++;
                $display("FAIL known_timing x=%h: lat=%0d busy=%0d done_next=%b want 18/18/0",
                         xs[i], lat, bcnt, da);
            end
`ifdef GF_INV16_ZERO_FLAG_EN
            n_vec++;
            if (bus.o_zero !== (xs[i] == 16'h0000)) begin
                n_err++;
                $display("FAIL known_zero x=%h: o_zero=%b want %b", xs[i], bus.o_zero, xs[i] == 16'h0000);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [15:0] x, r, e;
        int          lat, bcnt;
        logic        da;
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom_range(1, 65535));
            e = ref_inv(x);
            run_op(x, r, lat, bcnt, da);
            n_vec++;
            if (r !== e || lat !== 18) begin
                n_err++;
                $display("FAIL random x=%h: got %h lat %0d want %h lat 18", x, r, lat, e);
            end
            n_vec++;
            if (gf16_mul(x, r) !== 16'h0001) begin
                n_err++;
                $display("FAIL roundtrip x=%h: x*inv=%h want 0001", x, gf16_mul(x, r));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [$];
        logic [15:0] xc, e;
        int          k, last, got;
        @(negedge clk);
        xc = 16'($urandom_range(1, 65535));
        bus.i_start = 1'b1;
        bus.i_x = xc;
        exp_q.push_back(ref_inv(xc));
        @(negedge clk);
        k = 0; last = 0; got = 0;
        while (got < 3 && k < 100) begin
            if (bus.o_done) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.o_o !== e || (k - last) !== (got == 0 ? 18 : 19)) begin
                    n_err++;
                    $display("FAIL b2b result %0d: got %h gap %0d want %h gap %0d",
                             got, bus.o_o, k - last, e, got == 0 ? 18 : 19);
                end
                last = k;
                got++;
                if (got == 3) begin
                    bus.i_start = 1'b0;
                end else begin
                    xc = 16'($urandom_range(1, 65535));
                    bus.i_x = xc;
                    exp_q.push_back(ref_inv(xc));
                end
            end
            @(negedge clk);
            k++;
        end
        bus.i_start = 1'b0;
        n_vec++;
        if (got !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 3", got);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic [15:0] xa, xb, r;
        int          lat, extra;
        xa = 16'($urandom_range(1, 65535));
        xb = xa ^ 16'h5A5A;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_x = xa;
        @(negedge clk);
        bus.i_start = 1'b0;
        lat = -1; extra = 0; r = 16'h0;
        for (int k = 0; k < 40; k++) begin
            if (bus.o_done && lat < 0) begin
                lat = k;
                r = bus.o_o;
            end
            if (k >= 19 && (bus.o_done || bus.o_busy)) extra++;
            if (k == 4) begin
                bus.i_start = 1'b1;
                bus.i_x = xb;
            end else if (k == 5) begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if (r !== ref_inv(xa) || lat !== 18) begin
            n_err++;
            $display("FAIL busy_ignore: got %h lat %0d want %h lat 18", r, lat, ref_inv(xa));
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL busy_extra: %0d stray done/busy cycles want 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] xa, r;
        int          lat, bcnt, stray;
        logic        da;
        xa = 16'($urandom_range(1, 65535));
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_x = xa;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.o_o !== 16'h0000 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: o_o=%h done=%b busy=%b want 0000/0/0", bus.o_o, bus.o_done, bus.o_busy);
        end
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.o_done || bus.o_busy) stray++;
            @(negedge clk);
        end
        n_vec++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL mid_reset_stray: %0d cycles of done/busy want 0", stray);
        end
        rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_x = xa;
        @(negedge clk);
        rst = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vs_start: busy=%b want 0", bus.o_busy);
        end
        run_op(xa, r, lat, bcnt, da);
        n_vec++;
        if (r !== ref_inv(xa) || lat !== 18) begin
            n_err++;
            $display("FAIL after_reset: got %h lat %0d want %h lat 18", r, lat, ref_inv(xa));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_x = 16'h0;
        test_reset();
        test_known();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
